// File: rtl/toeplitz_pkg.sv
// Shared definitions for the Toeplitz accumulator datapath.
//   DEF_*      : default BS / N / L / STRIDE parameter values
//   DEF_STEP_W : step-counter width for the default configuration
//   state_e    : accumulator FSM state encoding
//   step_w()   : step-counter width for an arbitrary N / STRIDE pair
package toeplitz_pkg;

  localparam int unsigned DEF_BS     = 64;
  localparam int unsigned DEF_N      = 256;
  localparam int unsigned DEF_L      = 128;
  localparam int unsigned DEF_STRIDE = 4;
  localparam int unsigned DEF_STEP_W = $clog2(DEF_N / DEF_STRIDE);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // A one-step block still needs a 1-bit counter.
  function automatic int unsigned step_w(input int unsigned n, input int unsigned stride);
    return ((n / stride) > 1) ? $clog2(n / stride) : 1;
  endfunction

endpackage

// File: rtl/word_buf2.sv
// Two-entry raw data word buffer: a holding register behind a shift register.
// The shift register presents STRIDE bits per pop, LSB first.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   din_i/din_valid_i : incoming word and its valid
//   din_ready_o       : low during reset and when both entries are occupied
//   pop_i             : consume the STRIDE bits on bits_o
//   bits_o            : next STRIDE data bits
//   empty_o           : shift register holds no data
module word_buf2
  import toeplitz_pkg::*;
#(
  parameter int unsigned BS     = DEF_BS,
  parameter int unsigned STRIDE = DEF_STRIDE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BS-1:0]     din_i,
  input  logic              din_valid_i,
  output logic              din_ready_o,
  input  logic              pop_i,
  output logic [STRIDE-1:0] bits_o,
  output logic              empty_o
);

  localparam int unsigned CHUNKS = BS / STRIDE;
  localparam int unsigned CNT_W  = $clog2(CHUNKS + 1);

  logic [BS-1:0]    sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // STRIDE-bit chunks left in sh_q
  logic [BS-1:0]    hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             en_q;             // keeps din_ready low until the first edge after reset
  logic             push;

  // The holding register is only ever occupied while the shift register is,
  // so "both full" reduces to hold_vld_q.
  assign empty_o     = (cnt_q == '0);
  assign bits_o      = sh_q[STRIDE-1:0];
  assign din_ready_o = en_q && !(hold_vld_q && !empty_o);
  assign push        = din_valid_i && din_ready_o;

  always_comb begin
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (pop_i && !empty_o) begin
      if (cnt_q == CNT_W'(1)) begin
        // Last chunk drained: reload from the holding register in the same cycle.
        if (hold_vld_q) begin
          sh_d       = hold_q;
          cnt_d      = CNT_W'(CHUNKS);
          hold_vld_d = 1'b0;
        end else begin
          cnt_d = '0;
        end
      end else begin
        sh_d  = sh_q >> STRIDE;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    // A new word goes straight into the shift register if it will be empty,
    // otherwise into the (then necessarily free) holding register.
    if (push) begin
      if (cnt_d == '0) begin
        sh_d  = din_i;
        cnt_d = CNT_W'(CHUNKS);
      end else begin
        hold_d     = din_i;
        hold_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q       <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      en_q       <= 1'b1;
    end
  end

endmodule

// File: rtl/toeplitz_acc.sv
// Toeplitz hash accumulator: GF(2) matrix-vector product of an N-bit block
// against Toeplitz columns supplied STRIDE per cycle by free-running
// column generators. One L-bit hash is produced per block.
//   clk, reset              : clock, asynchronous active-high reset
//   cols                    : STRIDE columns, slice k = column c+k
//   col_first               : slice 0 carries column 0 this cycle
//   din/din_valid/din_ready : raw data word stream (bit i of word w = block bit w*BS+i)
//   hash/hash_valid/hash_ready : completed-block result handshake
//   err_underrun            : sticky, block aborted for lack of data
//   err_overrun             : sticky, completed hash dropped (output full)
// Requires BS % STRIDE == 0 and N % BS == 0.
module toeplitz_acc
  import toeplitz_pkg::*;
#(
  parameter int unsigned BS     = DEF_BS,
  parameter int unsigned N      = DEF_N,
  parameter int unsigned L      = DEF_L,
  parameter int unsigned STRIDE = DEF_STRIDE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [STRIDE*L-1:0] cols,
  input  logic                col_first,
  input  logic [BS-1:0]       din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [L-1:0]        hash,
  output logic                hash_valid,
  input  logic                hash_ready,
  output logic                err_underrun,
  output logic                err_overrun
);

  localparam int unsigned STEPS  = N / STRIDE;
  localparam int unsigned STEP_W = step_w(N, STRIDE);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [L-1:0]      acc_q, acc_d;
  logic [L-1:0]      hash_q, hash_d;
  logic              hv_q, hv_d;
  logic              eu_q, eu_d;
  logic              eo_q, eo_d;

  logic              do_step;
  logic              buf_empty;
  logic [STRIDE-1:0] bits;
  logic [L-1:0]      contrib;
  logic [L-1:0]      acc_next;

  word_buf2 #(
    .BS    (BS),
    .STRIDE(STRIDE)
  ) u_buf (
    .clk_i      (clk),
    .rst_i      (reset),
    .din_i      (din),
    .din_valid_i(din_valid),
    .din_ready_o(din_ready),
    .pop_i      (do_step),
    .bits_o     (bits),
    .empty_o    (buf_empty)
  );

  // XOR of the columns selected by this step's data bits; step 0 (taken
  // from IDLE) starts from a zero accumulator.
  always_comb begin
    contrib = '0;
    for (int unsigned k = 0; k < STRIDE; k++) begin
      if (bits[k]) contrib = contrib ^ cols[k*L +: L];
    end
    acc_next = ((state_q == IDLE) ? '0 : acc_q) ^ contrib;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    hash_d  = hash_q;
    hv_d    = hv_q;
    eu_d    = eu_q;
    eo_d    = eo_q;
    do_step = 1'b0;

    if (hv_q && hash_ready) hv_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (col_first && !buf_empty) do_step = 1'b1;
      end
      ACCUM: begin
        if (buf_empty) begin
          // Starved mid-block: abort, keep any words that arrive later.
          eu_d    = 1'b1;
          acc_d   = '0;
          step_d  = '0;
          state_d = IDLE;
        end else begin
          do_step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_step) begin
      if (step_q == LAST_STEP) begin
        acc_d   = '0;
        step_d  = '0;
        state_d = IDLE;
        // A new result overrides the clear from a same-cycle handshake.
        if (!hv_q || hash_ready) begin
          hash_d = acc_next;
          hv_d   = 1'b1;
        end else begin
          eo_d = 1'b1;
        end
      end else begin
        acc_d   = acc_next;
        step_d  = step_q + STEP_W'(1);
        state_d = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      hash_q  <= '0;
      hv_q    <= 1'b0;
      eu_q    <= 1'b0;
      eo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      hash_q  <= hash_d;
      hv_q    <= hv_d;
      eu_q    <= eu_d;
      eo_q    <= eo_d;
    end
  end

  assign hash         = hash_q;
  assign hash_valid   = hv_q;
  assign err_underrun = eu_q;
  assign err_overrun  = eo_q;

endmodule

// File: tb/tb_toeplitz_acc.sv
module tb_toeplitz_acc;

  localparam int unsigned BS = 64;
  localparam int unsigned N  = 256;
  localparam int unsigned L  = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4*L-1:0] cols4;
  logic [2*L-1:0] cols2;
  logic [L-1:0]   cols1;
  logic           cf4, cf2, cf1;
  logic [BS-1:0]  din4, din2, din1;
  logic           dv4, dv2, dv1, dr4, dr2, dr1;
  logic [L-1:0]   h4, h2, h1;
  logic           hv4, hv2, hv1, hr4, hr2, hr1;
  logic           eu4, eu2, eu1, eo4, eo2, eo1;

  toeplitz_acc #(.BS(BS), .N(N), .L(L), .STRIDE(4)) dut (
    .clk(clk), .reset(reset), .cols(cols4), .col_first(cf4), .din(din4), .din_valid(dv4),
    .din_ready(dr4), .hash(h4), .hash_valid(hv4), .hash_ready(hr4),
    .err_underrun(eu4), .err_overrun(eo4));

  toeplitz_acc #(.BS(BS), .N(N), .L(L), .STRIDE(2)) dut_s2 (
    .clk(clk), .reset(reset), .cols(cols2), .col_first(cf2), .din(din2), .din_valid(dv2),
    .din_ready(dr2), .hash(h2), .hash_valid(hv2), .hash_ready(hr2),
    .err_underrun(eu2), .err_overrun(eo2));

  toeplitz_acc #(.BS(BS), .N(N), .L(L), .STRIDE(1)) dut_s1 (
    .clk(clk), .reset(reset), .cols(cols1), .col_first(cf1), .din(din1), .din_valid(dv1),
    .din_ready(dr1), .hash(h1), .hash_valid(hv1), .hash_ready(hr1),
    .err_underrun(eu1), .err_overrun(eo1));

  // Toeplitz seed: column c, row r = seed[N-1-c+r] (constant along diagonals).
  logic [N+L-2:0] seed;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned c4, c2, c1, cyc;
  logic [BS-1:0] wq [3][32];
  int unsigned   wlen [3];
  int unsigned   wptr [3];

  function automatic logic [L-1:0] gcol(input int unsigned c);
    logic [L-1:0] g;
    for (int unsigned r = 0; r < L; r++) g[r] = seed[N-1-c+r];
    return g;
  endfunction

  function automatic logic [L-1:0] ref_hash(input logic [N-1:0] blk);
    logic [L-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) if (blk[i]) r = r ^ gcol(i);
    return r;
  endfunction

  function automatic logic [4*L-1:0] mkcols(input int unsigned base, input int unsigned stride);
    logic [4*L-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < stride; k++) t[k*L +: L] = gcol(base + k);
    return t;
  endfunction

  task automatic check(input string tag, input logic [L-1:0] got, input logic [L-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive();
    logic [4*L-1:0] t;
    dv4  = (wptr[0] < wlen[0]);
    din4 = dv4 ? wq[0][wptr[0]] : '0;
    dv2  = (wptr[1] < wlen[1]);
    din2 = dv2 ? wq[1][wptr[1]] : '0;
    dv1  = (wptr[2] < wlen[2]);
    din1 = dv1 ? wq[2][wptr[2]] : '0;
    cf4 = (c4 == 0);
    cf2 = (c2 == 0);
    cf1 = (c1 == 0);
    cols4 = mkcols(c4 * 4, 4);
    t = mkcols(c2 * 2, 2);
    cols2 = t[2*L-1:0];
    t = mkcols(c1, 1);
    cols1 = t[L-1:0];
  endtask

  // One clock: note which words the edge accepts, advance the column generators.
  task automatic tick();
    bit a0, a1, a2;
    a0 = dv4 && dr4;
    a1 = dv2 && dr2;
    a2 = dv1 && dr1;
    @(posedge clk);
    #1;
    cyc++;
    if (a0) wptr[0]++;
    if (a1) wptr[1]++;
    if (a2) wptr[2]++;
    if (reset) begin
      c4 = 0; c2 = 0; c1 = 0;
    end else begin
      c4 = (c4 + 1) % (N / 4);
      c2 = (c2 + 1) % (N / 2);
      c1 = (c1 + 1) % N;
    end
    drive();
  endtask

  task automatic load(input int unsigned idx, input logic [N-1:0] blk);
    for (int unsigned w = 0; w < N / BS; w++) begin
      wq[idx][wlen[idx]] = blk[w*BS +: BS];
      wlen[idx]++;
    end
    drive();
  endtask

  task automatic push_word(input int unsigned idx, input logic [BS-1:0] w);
    wq[idx][wlen[idx]] = w;
    wlen[idx]++;
    drive();
  endtask

  function automatic logic sig(input int unsigned which);
    case (which)
      0: return hv4;
      1: return eu4;
      2: return eo4;
      3: return hv2;
      default: return hv1;
    endcase
  endfunction

  task automatic wait_sig(input int unsigned which, input int unsigned limit, input string tag);
    int unsigned n;
    n = 0;
    while (!sig(which) && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, L'(sig(which)), L'(1));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hash"}, h4, '0);
    check({tag, "_hv"}, L'(hv4), '0);
    check({tag, "_eu"}, L'(eu4), '0);
    check({tag, "_eo"}, L'(eo4), '0);
    check({tag, "_rdy"}, L'(dr4), '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] blk, blk_a, blk_b, blk_c, blk_d, blk133;
    logic [383:0] s;
    int unsigned  cyc_a;

    s = {64'h9E3779B97F4A7C15, 64'hC2B2AE3D27D4EB4F, 64'h165667B19E3779F9,
         64'hD6E8FEB86659FD93, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1};
    seed = s[N+L-2:0];
    blk_a = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h00FF00FF0F0F0F0F, 64'h8000000000000001};
    blk_b = {64'hDEADBEEFCAFEF00D, 64'h5555AAAA3333CCCC, 64'h1, 64'hFFFFFFFFFFFFFFFF};
    blk_c = {64'h13579BDF2468ACE0, 64'h0, 64'h7777777777777777, 64'h0000000100000000};
    blk_d = {64'hF0F0F0F0F0F0F0F0, 64'h1234, 64'hABCDEF, 64'h8421842184218421};
    blk133 = '0;
    blk133[133] = 1'b1;

    for (int unsigned i = 0; i < 3; i++) begin
      wlen[i] = 0;
      wptr[i] = 0;
    end
    c4 = 0; c2 = 0; c1 = 0; cyc = 0;
    hr4 = 1'b1; hr2 = 1'b0; hr1 = 1'b0;
    reset = 1'b1;
    drive();
    #1;
    check_reset_state("rst");
    tick();
    tick();
    reset = 1'b0;
    drive();
    check("rdy_before_edge", L'(dr4), '0);
    tick();
    check("rdy_after_rst", L'(dr4), L'(1));

    // Zero block, also checks 1-cycle latency after step 63.
    load(0, '0);
    wait_sig(0, 300, "zero");
    check("zero_latency", L'(c4), '0);
    check("zero_hash", h4, '0);
    tick();
    check("zero_hv_clear", L'(hv4), '0);

    // Single bit 0 selects column 0.
    blk = '0;
    blk[0] = 1'b1;
    load(0, blk);
    wait_sig(0, 300, "bit0");
    check("bit0_hash", h4, gcol(0));
    tick();

    // Single bit 133 selects column 133.
    load(0, blk133);
    wait_sig(0, 300, "bit133");
    check("bit133_hash", h4, gcol(133));
    tick();

    // Back-to-back blocks with no gap.
    load(0, blk_a);
    load(0, blk_b);
    wait_sig(0, 300, "b2b_a");
    check("b2b_a_hash", h4, ref_hash(blk_a));
    cyc_a = cyc;
    tick();
    wait_sig(0, 100, "b2b_b");
    check("b2b_b_hash", h4, ref_hash(blk_b));
    check("b2b_gap", L'(cyc - cyc_a), L'(64));
    check("b2b_errs", L'({eu4, eo4}), '0);
    tick();

    // Underrun: one word only, abort at step 16, then recover.
    push_word(0, 64'hA5A5A5A5A5A5A5A5);
    wait_sig(1, 300, "urun");
    check("urun_step", L'(c4), L'(17));
    check("urun_hv", L'(hv4), '0);
    load(0, blk_c);
    wait_sig(0, 300, "urun_rec");
    check("urun_rec_hash", h4, ref_hash(blk_c));
    tick();

    // Backpressure: first hash held, second dropped.
    hr4 = 1'b0;
    load(0, blk_a);
    load(0, blk_b);
    load(0, blk_d);
    wait_sig(0, 300, "bp_a");
    check("bp_a_hash", h4, ref_hash(blk_a));
    wait_sig(2, 200, "bp_ovr");
    check("bp_ovr_step", L'(c4), '0);
    check("bp_held_hash", h4, ref_hash(blk_a));
    check("bp_held_hv", L'(hv4), L'(1));
    check("urun_sticky", L'(eu4), L'(1));

    // Reset after step 30 of the third block.
    while (c4 != 31) tick();
    reset = 1'b1;
    #1;
    check_reset_state("midrst");
    wlen[0] = wptr[0];
    hr4 = 1'b1;
    tick();
    reset = 1'b0;
    drive();
    check("midrst_rdy_before_edge", L'(dr4), '0);
    tick();
    check("midrst_rdy_after", L'(dr4), L'(1));

    // Same bit-133 block at STRIDE 2 and 1 must give the same column.
    load(1, blk133);
    load(2, blk133);
    wait_sig(3, 400, "s2");
    check("s2_hash", h2, gcol(133));
    wait_sig(4, 700, "s1");
    check("s1_hash", h1, gcol(133));
    check("s_errs", L'({eu2, eo2, eu1, eo1}), '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
